// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared width, port FSM state and operation encodings for mem_responder.
package mem_responder_pkg;
    localparam int WORD_SIZE = 16;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/mem_port_fsm.sv
// mem_port_fsm: one request port; latches the access, counts out the latency and pulses o_ready.
module mem_port_fsm
    import mem_responder_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_ready,
    output logic          o_op,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_req;
    assign w_req = i_rd || i_wr;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            o_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req) begin
                    o_op    <= i_wr ? OP_WRITE : OP_READ;
                    o_addr  <= i_addr;
                    o_wdata <= i_wdata;
                    r_cnt   <= CW'(LATENCY - 1);
                    r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    o_ready <= (LATENCY == 1);
                end
                // a dropped request abandons the access before it touches the array
                ST_WAIT: if (!w_req) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_RESP;
                        o_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    o_ready <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: shared word memory behind independent I and D ports with fixed latency.
// Optional rd_count/wr_count access counters under `MEM_ACCESS_COUNT_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = mem_responder_pkg::WORD_SIZE,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    inout  wire  [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 d_ready
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [WORD_SIZE-1:0] rd_count,
    output logic [WORD_SIZE-1:0] wr_count
`endif
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH];
    logic [AW-1:0]        w_i_addr, w_d_addr;
    logic [WORD_SIZE-1:0] w_d_wdata, w_i_wdata_unused;
    logic                 w_d_op, w_i_op_unused, w_d_rd_en, w_d_wr_en, w_unused_addr;
    assign w_unused_addr = &{1'b0, i_address[WORD_SIZE-1:AW], d_address[WORD_SIZE-1:AW]};
    mem_port_fsm #(.AW(AW), .DW(WORD_SIZE), .LATENCY(LATENCY)) u_i_port (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rd    (i_readM),
        .i_wr    (1'b0),
        .i_addr  (i_address[AW-1:0]),
        .i_wdata ('0),
        .o_ready (i_ready),
        .o_op    (w_i_op_unused),
        .o_addr  (w_i_addr),
        .o_wdata (w_i_wdata_unused)
    );
    mem_port_fsm #(.AW(AW), .DW(WORD_SIZE), .LATENCY(LATENCY)) u_d_port (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rd    (d_readM),
        .i_wr    (d_writeM),
        .i_addr  (d_address[AW-1:0]),
        .i_wdata (d_data),
        .o_ready (d_ready),
        .o_op    (w_d_op),
        .o_addr  (w_d_addr),
        .o_wdata (w_d_wdata)
    );
    assign w_d_rd_en = d_ready && (w_d_op == OP_READ);
    assign w_d_wr_en = d_ready && (w_d_op == OP_WRITE);
    // reads are combinational from the array, so a same-cycle D write is seen only afterwards
    assign i_data = i_ready   ? r_mem[w_i_addr] : 'z;
    assign d_data = w_d_rd_en ? r_mem[w_d_addr] : 'z;
    always_ff @(posedge clk) begin
        if (reset_n && w_d_wr_en) r_mem[w_d_addr] <= w_d_wdata;
    end
`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_count <= rd_count + WORD_SIZE'(i_ready) + WORD_SIZE'(w_d_rd_en);
            wr_count <= wr_count + WORD_SIZE'(w_d_wr_en);
        end
    end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed tests with a per-cycle reference model of mem_responder (LATENCY=2, depth 256).
module tb_mem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;
    localparam logic [15:0] FLOAT = 16'hFFFF;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        i_readM = 1'b0, d_readM = 1'b0, d_writeM = 1'b0, d_oe = 1'b0;
    logic [15:0] i_address = '0, d_address = '0, d_wdrv = '0;
    tri1  [15:0] i_data, d_data;
    logic        i_ready, d_ready;
`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count, wr_count;
`endif
    assign d_data = d_oe ? d_wdrv : 'z;

    mem_responder #(.WORD_SIZE(16), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_readM   (i_readM),
        .i_address (i_address),
        .i_data    (i_data),
        .i_ready   (i_ready),
        .d_readM   (d_readM),
        .d_writeM  (d_writeM),
        .d_address (d_address),
        .d_data    (d_data),
        .d_ready   (d_ready)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: each port has an absolute due cycle for its response, -1 when free.
    logic [15:0] mm [DEPTH];
    int          cyc = 0, i_due = -1, d_due = -1, i_a, d_a, drdy = 0;
    logic        d_op;
    logic [15:0] d_wd;
    int          rdc = 0, wrc = 0;
    always @(posedge clk) begin
        if (!reset_n) begin
            i_due = -1; d_due = -1; rdc = 0; wrc = 0;
        end else begin
            if (i_due == cyc) begin
                rdc++; i_due = -1;
            end else if (i_due > cyc && !i_readM) i_due = -1;
            else if (i_due < 0 && i_readM) begin
                i_due = cyc + LAT; i_a = i_address % DEPTH;
            end
            if (d_due == cyc) begin
                if (d_op) begin mm[d_a] = d_wd; wrc++; end
                else rdc++;
                d_due = -1;
            end else if (d_due > cyc && !(d_readM || d_writeM)) d_due = -1;
            else if (d_due < 0 && (d_readM || d_writeM)) begin
                d_due = cyc + LAT; d_op = d_writeM; d_a = d_address % DEPTH; d_wd = d_data;
            end
        end
        cyc++;
        #1;
        chk("i_ready", i_ready, i_due == cyc);
        chk("i_data", i_data, (i_due == cyc) ? mm[i_a] : FLOAT);
        chk("d_ready", d_ready, d_due == cyc);
        chk("d_data", d_data, (d_due == cyc && !d_op) ? mm[d_a] : (d_oe ? d_wdrv : FLOAT));
`ifdef MEM_ACCESS_COUNT_EN
        chk("rd_count", rd_count, rdc[15:0]);
        chk("wr_count", wr_count, wrc[15:0]);
`endif
        if (d_ready) drdy++;
    end

    task automatic i_req(input logic [15:0] a, output logic [15:0] got, output logic [15:0] pre,
                         output logic [15:0] post, output int lat);
        int s, rc;
        @(negedge clk); i_readM = 1'b1; i_address = a;
        s = cyc; rc = -1; got = '0; pre = '0;
        for (int n = 1; n <= 20 && rc < 0; n++) begin
            @(posedge clk); #2;
            if (n == 1) pre = i_data;
            if (i_ready) begin rc = cyc; got = i_data; end
        end
        if (rc < 0) chk("i_timeout", 0, 1);
        lat = rc - s;
        @(negedge clk); i_readM = 1'b0;
        @(posedge clk); #2; post = i_data;
    endtask

    task automatic d_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] got, output int lat, output int rc);
        int s;
        @(negedge clk); d_readM = rd; d_writeM = wr; d_address = a; d_wdrv = wd; d_oe = wr;
        s = cyc; rc = -1; got = '0;
        for (int n = 1; n <= 20 && rc < 0; n++) begin
            @(posedge clk); #2;
            if (d_ready) begin rc = cyc; got = d_data; end
        end
        if (rc < 0) chk("d_timeout", 0, 1);
        lat = rc - s;
        @(negedge clk); d_readM = 1'b0; d_writeM = 1'b0; d_oe = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    logic [15:0] g, g2, pre, post;
    int          lat, lat2, rc, rc2, base;
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_data", d_data, FLOAT);
        // basic I read with bus float around the pulse
        d_req(0, 1, 16'h0010, 16'hBEEF, g, lat, rc);
        i_req(16'h0010, g, pre, post, lat);
        chk("i_rd_data", g, 16'hBEEF);
        chk("i_rd_lat", lat, 2);
        chk("i_pre_float", pre, FLOAT);
        chk("i_post_float", post, FLOAT);
        // write then read back, spaced LATENCY+1
        d_req(0, 1, 16'h0020, 16'h1234, g, lat, rc);
        d_req(1, 0, 16'h0020, 16'h0000, g2, lat2, rc2);
        chk("d_wr_lat", lat, 2);
        chk("d_rd_data", g2, 16'h1234);
        chk("d_spacing", rc2 - rc, 3);
        // read-before-write collision
        d_req(0, 1, 16'h0030, 16'hAAAA, g, lat, rc);
        fork
            i_req(16'h0030, g, pre, post, lat);
            d_req(0, 1, 16'h0030, 16'h5555, g2, lat2, rc2);
        join
        chk("coll_i_old", g, 16'hAAAA);
        d_req(1, 0, 16'h0030, 16'h0000, g, lat, rc);
        chk("coll_new", g, 16'h5555);
        // write aborted by dropping the request
        d_req(0, 1, 16'h0040, 16'h4040, g, lat, rc);
        base = drdy;
        @(negedge clk); d_writeM = 1'b1; d_address = 16'h0040; d_wdrv = 16'h7777; d_oe = 1'b1;
        @(negedge clk); d_writeM = 1'b0; d_oe = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_rdy", drdy - base, 0);
        d_req(1, 0, 16'h0040, 16'h0000, g, lat, rc);
        chk("abort_mem", g, 16'h4040);
        // reset during WAIT
        base = drdy;
        @(negedge clk); d_writeM = 1'b1; d_address = 16'h0040; d_wdrv = 16'h7777; d_oe = 1'b1;
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #2;
        chk("rstw_i_float", i_data, FLOAT);
        @(negedge clk); reset_n = 1'b1; d_writeM = 1'b0; d_oe = 1'b0;
        @(posedge clk); #2;
        chk("rstw_d_float", d_data, FLOAT);
        repeat (3) @(negedge clk);
        chk("rstw_rdy", drdy - base, 0);
        d_req(1, 0, 16'h0040, 16'h0000, g, lat, rc);
        chk("rstw_mem", g, 16'h4040);
        // reset sampled in the RESP cycle suppresses the commit
        base = drdy;
        @(negedge clk); d_writeM = 1'b1; d_address = 16'h0040; d_wdrv = 16'h7777; d_oe = 1'b1;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; d_writeM = 1'b0; d_oe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstr_rdy", drdy - base, 1);
        d_req(1, 0, 16'h0040, 16'h0000, g, lat, rc);
        chk("rstr_mem", g, 16'h4040);
        // address wrap and read+write priority
        d_req(0, 1, 16'h0150, 16'h0F0F, g, lat, rc);
        d_req(1, 0, 16'h0050, 16'h0000, g, lat, rc);
        chk("wrap", g, 16'h0F0F);
        d_req(1, 1, 16'h0060, 16'hCAFE, g, lat, rc);
        d_req(1, 0, 16'h0060, 16'h0000, g, lat, rc);
        chk("rw_is_write", g, 16'hCAFE);
`ifdef MEM_ACCESS_COUNT_EN
        pulse_reset();
        fork
            i_req(16'h0010, g, pre, post, lat);
            d_req(1, 0, 16'h0020, 16'h0000, g2, lat2, rc2);
        join
        d_req(1, 0, 16'h0030, 16'h0000, g, lat, rc);
        d_req(0, 1, 16'h0070, 16'h1111, g, lat, rc);
        d_req(0, 1, 16'h0071, 16'h2222, g, lat, rc);
        @(posedge clk); #2;
        chk("cnt_rd", rd_count, 3);
        chk("cnt_wr", wr_count, 2);
        pulse_reset();
        @(posedge clk); #2;
        chk("cnt_rd_rst", rd_count, 0);
        chk("cnt_wr_rst", wr_count, 0);
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end
endmodule
